fir_filter_param: RTL and testbench
===================================

FIR_FILTER_PARAM -- requirements
Module: fir_filter_param

Interface
REQ-001 Parameter DW, default 16, signed sample width of x_in and y_out (8..32).
REQ-002 Parameter CW, default 16, signed coefficient width (8..32).
REQ-003 Parameter TAPS, default 8, number of taps (2..32).
REQ-004 Parameter FRAC, default 15, number of coefficient fraction bits removed from the accumulator (0..CW-1).
REQ-005 Port clk, input, 1, single clock; all logic SHALL be rising-edge clocked.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port in_valid, input, 1, x_in is a new sample this cycle.
REQ-008 Port x_in, input, DW, signed input sample.
REQ-009 Port coef_we, input, 1, coefficient write strobe.
REQ-010 Port coef_addr, input, clog2(TAPS), tap index for the write.
REQ-011 Port coef_data, input, CW, signed coefficient value.
REQ-012 Port out_valid, output, 1, y_out holds a new result.
REQ-013 Port y_out, output, DW, signed filtered sample, registered.
REQ-014 Port sat_flag, output, 1, the current y_out was clamped; registered alongside y_out.

Function
REQ-015 Delay line: TAPS x DW registers; shift by one and load x_in into tap 0 only on cycles where in_valid=1; hold otherwise.
REQ-016 Stage 1, in the cycle after an accepted sample: register all TAPS products x[k]*c[k] at full DW+CW width.
REQ-017 Stage 2: register y_out = (sum of products + 2^(FRAC-1)) >>> FRAC (arithmetic); add no rounding term when FRAC=0.
REQ-018 Accumulator width: DW+CW+clog2(TAPS); no intermediate overflow.
REQ-019 Latency: in_valid at edge N gives out_valid=1 at edge N+2, high for exactly one cycle per accepted sample; back-to-back input gives back-to-back output.
REQ-020 y_out and sat_flag SHALL hold their value while out_valid=0.
REQ-021 Coefficient write: with coef_we=1, coef[coef_addr] <= coef_data at the edge; an in-range write SHALL NOT affect the sample accepted in the same cycle and SHALL apply from the next accepted sample.
REQ-022 A write with coef_addr >= TAPS SHALL be ignored.
REQ-023 An in_valid gap SHALL NOT alter delay line contents or add outputs; the pipeline drains normally.

Reset
REQ-024 Synchronous reset SHALL clear the delay line, product registers, all coefficients, y_out, out_valid and sat_flag to 0 at the next edge.
REQ-025 Reset mid-stream: in-flight results are discarded; out_valid=0 from the first edge with reset high until 2 edges after the first post-reset accepted sample.
REQ-026 in_valid and coef_we SHALL be ignored while reset=1.

Configuration
REQ-027 Macro FIR_FILTER_SAT_EN defined: a result outside [-2^(DW-1), 2^(DW-1)-1] clamps to the nearer bound, and sat_flag=1 for that output.
REQ-028 Macro undefined: y_out is the low DW bits of the result (wrap), and sat_flag is tied to 0.

Structure
REQ-029 Package fir_filter_pkg SHALL hold the default parameter constants, a function giving the accumulator width, and the saturation bounds function.
REQ-030 One sub-module, fir_mac_tree: combinational signed adder tree over the TAPS products, parametrised by TAPS and product width.

Verification (DW=16, CW=16, TAPS=4, FRAC=15)
REQ-031 Impulse: all coefficients 0x4000; one x_in=32767 sample, then zeros each cycle -> y_out=16384 for 4 consecutive outputs, then 0; first out_valid 2 cycles after the impulse.
REQ-032 Overflow: all coefficients 0x7FFF; x_in=32767 for 4 samples -> 4th output y_out=32767 with sat_flag=1 when the macro is defined; y_out=-8 with sat_flag=0 when it is undefined.
REQ-033 Valid gaps: impulse with in_valid pulsed every 3rd cycle -> same 4 x 16384 sequence, one out_valid per accepted sample, delay line unchanged during gaps.
REQ-034 Coefficient write: coef[0] 0x4000 -> 0x2000, written in the same cycle as impulse 32767 -> that output is 16384; the next impulse gives 8192.
REQ-035 Reset mid-stream: reset asserted 1 cycle after an impulse -> no out_valid for that impulse; y_out=0; coefficients read back 0, so the next impulse gives 0.
REQ-036 Out-of-range write: coef_addr=5 with TAPS=8 retargeted to TAPS=4 (clog2=2 gives addr wrap test only at TAPS=6, addr=7) -> no coefficient changes, and output matches the pre-write response.

Source files
------------

// File: rtl/fir_filter_pkg.sv
// fir_filter_pkg: shared defaults, accumulator sizing and saturation bounds for fir_filter_param.
package fir_filter_pkg;

    localparam int DEF_DW   = 16;
    localparam int DEF_CW   = 16;
    localparam int DEF_TAPS = 8;
    localparam int DEF_FRAC = 15;

    function automatic int acc_w(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

    // Largest (hi=1) or smallest (hi=0) value representable in a dw-bit signed sample.
    function automatic longint sat_bound(input int dw, input bit hi);
        return hi ? (64'sd1 <<< (dw - 1)) - 64'sd1 : -(64'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// fir_filter_param_if: sample, coefficient-write and result signals of the FIR filter.
interface fir_filter_param_if
    import fir_filter_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int CW   = DEF_CW,
    parameter int TAPS = DEF_TAPS
);
    logic                      in_valid;
    logic signed [DW-1:0]      x_in;
    logic                      coef_we;
    logic [$clog2(TAPS)-1:0]   coef_addr;
    logic signed [CW-1:0]      coef_data;
    logic                      out_valid;
    logic signed [DW-1:0]      y_out;
    logic                      sat_flag;

    modport master (
        output in_valid, x_in, coef_we, coef_addr, coef_data,
        input  out_valid, y_out, sat_flag
    );

    modport slave (
        input  in_valid, x_in, coef_we, coef_addr, coef_data,
        output out_valid, y_out, sat_flag
    );
endinterface

// File: rtl/fir_mac_tree.sv
// fir_mac_tree: combinational signed adder tree summing TAPS products of width PW.
module fir_mac_tree #(
    parameter int TAPS = 8,
    parameter int PW   = 32
) (
    input  logic signed [PW-1:0]               i_p [TAPS],
    output logic signed [PW+$clog2(TAPS)-1:0]  o_sum
);
    localparam int L  = $clog2(TAPS);
    localparam int N  = 1 << L;
    localparam int OW = PW + L;

    // Leaves are padded with zeros up to the next power of two.
    for (genvar l = 0; l <= L; l++) begin : g_lvl
        logic signed [OW-1:0] w_s [N >> l];
        for (genvar i = 0; i < (N >> l); i++) begin : g_n
            if (l == 0) begin : g_leaf
                if (i < TAPS) begin : g_p
                    assign w_s[i] = OW'(i_p[i]);
                end else begin : g_z
                    assign w_s[i] = '0;
                end
            end else begin : g_add
                assign w_s[i] = g_lvl[l-1].w_s[2*i] + g_lvl[l-1].w_s[2*i+1];
            end
        end
    end

    assign o_sum = g_lvl[L].w_s[0];
endmodule

// File: rtl/fir_filter_param.sv
// fir_filter_param: two-stage pipelined FIR with writable coefficients and rounding.
// Define FIR_FILTER_SAT_EN to clamp out-of-range results (sat_flag); otherwise results wrap.
module fir_filter_param
    import fir_filter_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int CW   = DEF_CW,
    parameter int TAPS = DEF_TAPS,
    parameter int FRAC = DEF_FRAC
) (
    input logic               clk,
    input logic               reset,
    fir_filter_param_if.slave bus
);
    localparam int PW = DW + CW;
    localparam int AW = acc_w(DW, CW, TAPS);
    localparam logic signed [AW-1:0] RND = (AW'(1) << FRAC) >> 1;

    logic signed [DW-1:0] r_x  [TAPS];
    logic signed [CW-1:0] r_c  [TAPS];
    logic signed [CW-1:0] r_cs [TAPS];
    logic signed [PW-1:0] r_p  [TAPS];
    logic                 r_sv;
    logic                 r_pv;
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] w_res;
    logic signed [DW-1:0] w_y;
    logic                 w_sat;

    fir_mac_tree #(.TAPS(TAPS), .PW(PW)) u_tree (.i_p(r_p), .o_sum(w_sum));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x           <= '{default: '0};
            r_c           <= '{default: '0};
            r_cs          <= '{default: '0};
            r_p           <= '{default: '0};
            r_sv          <= 1'b0;
            r_pv          <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.y_out     <= '0;
            bus.sat_flag  <= 1'b0;
        end else begin
            // r_cs freezes the coefficients seen by this sample, so a same-edge write only hits later samples.
            if (bus.in_valid) begin
                r_x[0] <= bus.x_in;
                for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
                r_cs <= r_c;
            end
            if (bus.coef_we && int'(bus.coef_addr) < TAPS) r_c[bus.coef_addr] <= bus.coef_data;
            if (r_sv) for (int k = 0; k < TAPS; k++) r_p[k] <= PW'(r_x[k]) * PW'(r_cs[k]);
            r_sv          <= bus.in_valid;
            r_pv          <= r_sv;
            bus.out_valid <= r_pv;
            if (r_pv) begin
                bus.y_out    <= w_y;
                bus.sat_flag <= w_sat;
            end
        end
    end

`ifdef FIR_FILTER_SAT_EN
    localparam logic signed [AW-1:0] HI = AW'(sat_bound(DW, 1'b1));
    localparam logic signed [AW-1:0] LO = AW'(sat_bound(DW, 1'b0));
    always_comb begin
        w_res = (w_sum + RND) >>> FRAC;
        w_sat = (w_res > HI) || (w_res < LO);
        w_y   = w_res > HI ? DW'(HI) : w_res < LO ? DW'(LO) : w_res[DW-1:0];
    end
`else
    always_comb begin
        w_res = (w_sum + RND) >>> FRAC;
        w_sat = 1'b0;
        w_y   = w_res[DW-1:0];
    end
`endif
endmodule

// File: tb/tb_fir_filter_param.sv
// tb_fir_filter_param: scoreboard bench for fir_filter_param (DW=CW=16, TAPS=4, FRAC=15) plus a TAPS=6 instance.
module tb_fir_filter_param;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    fir_filter_param_if #(.DW(16), .CW(16), .TAPS(4)) bus ();
    fir_filter_param_if #(.DW(16), .CW(16), .TAPS(6)) bus6 ();

    fir_filter_param #(.DW(16), .CW(16), .TAPS(4), .FRAC(15)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    fir_filter_param #(.DW(16), .CW(16), .TAPS(6), .FRAC(15)) dut6 (
        .clk(clk), .reset(reset), .bus(bus6.slave));

    logic signed [15:0] m_x [4];
    logic signed [15:0] m_c [4];
    logic [16:0]        sb [$];
    logic [16:0]        sb_e;
    logic signed [15:0] obs_y [$];
    logic               obs_s [$];
    int                 obs_t [$];

    function automatic logic [16:0] model_out();
        longint acc = 0;
        for (int k = 0; k < 4; k++) acc += longint'(m_x[k]) * longint'(m_c[k]);
        acc = (acc + 64'sd16384) >>> 15;
`ifdef FIR_FILTER_SAT_EN
        if (acc > 32767) return {1'b1, 16'h7FFF};
        if (acc < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, acc[15:0]};
    endfunction

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            obs_y.push_back(bus.y_out);
            obs_s.push_back(bus.sat_flag);
            obs_t.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got y=%0d sat=%b, expected no output", bus.y_out, bus.sat_flag);
            end else begin
                sb_e = sb.pop_front();
                if ({bus.sat_flag, bus.y_out} !== sb_e) begin
                    errors++;
                    $display("FAIL sb_output: got y=%0d sat=%b, expected y=%0d sat=%b",
                             bus.y_out, bus.sat_flag, $signed(sb_e[15:0]), sb_e[16]);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] x, input logic we = 1'b0,
                        input logic [1:0] a = 2'd0, input logic [15:0] d = 16'd0, input logic r = 1'b0);
        @(negedge clk);
        #1;
        reset = r;
        bus.in_valid = v;
        bus.x_in = x;
        bus.coef_we = we;
        bus.coef_addr = a;
        bus.coef_data = d;
        if (r) begin
            sb.delete();
            for (int k = 0; k < 4; k++) begin
                m_x[k] = '0;
                m_c[k] = '0;
            end
        end else begin
            if (v) begin
                for (int k = 3; k > 0; k--) m_x[k] = m_x[k-1];
                m_x[0] = x;
                sb.push_back(model_out());
            end
            if (we) m_c[a] = d;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'd0);
    endtask

    task automatic clear_obs();
        obs_y.delete();
        obs_s.delete();
        obs_t.delete();
    endtask

    task automatic set_coefs(input logic [15:0] c);
        for (int k = 0; k < 4; k++) step(1'b0, 16'd0, 1'b1, 2'(k), c);
    endtask

    task automatic test_reset();
        step(1'b0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b1);
        step(1'b0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bus.out_valid); end
        checks++;
        if (bus.y_out !== 16'sd0) begin errors++; $display("FAIL reset_y: got %0d, expected 0", bus.y_out); end
        checks++;
        if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b, expected 0", bus.sat_flag); end
    endtask

    task automatic test_impulse();
        int t0;
        logic signed [15:0] got;
        set_coefs(16'h4000);
        idle(4);
        clear_obs();
        step(1'b1, 16'sd32767);
        t0 = cyc + 1;
        repeat (6) step(1'b1, 16'd0);
        idle(3);
        checks++;
        if (obs_y.size() != 7) begin errors++; $display("FAIL impulse_count: got %0d outputs, expected 7", obs_y.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < obs_y.size()) ? obs_y[i] : 16'hxxxx;
            checks++;
            if (got !== ((i < 4) ? 16'sd16384 : 16'sd0)) begin
                errors++;
                $display("FAIL impulse_y[%0d]: got %0d, expected %0d", i, got, (i < 4) ? 16384 : 0);
            end
        end
        checks++;
        if (obs_t.size() == 0 || obs_t[0] - t0 != 2) begin
            errors++;
            $display("FAIL impulse_latency: got %0d, expected 2", (obs_t.size() == 0) ? -1 : obs_t[0] - t0);
        end
    endtask

    task automatic test_overflow();
        logic signed [15:0] exp_y;
        logic               exp_s;
`ifdef FIR_FILTER_SAT_EN
        exp_y = 16'sd32767;
        exp_s = 1'b1;
`else
        exp_y = -16'sd8;
        exp_s = 1'b0;
`endif
        set_coefs(16'h7FFF);
        idle(4);
        clear_obs();
        repeat (4) step(1'b1, 16'sd32767);
        idle(4);
        checks++;
        if (obs_y.size() != 4 || obs_y[3] !== exp_y || obs_s[3] !== exp_s) begin
            errors++;
            $display("FAIL overflow_4th: got n=%0d y=%0d sat=%b, expected n=4 y=%0d sat=%b", obs_y.size(),
                     (obs_y.size() == 4) ? obs_y[3] : 16'sd0, (obs_s.size() == 4) ? obs_s[3] : 1'b0, exp_y, exp_s);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.y_out !== exp_y || bus.sat_flag !== exp_s) begin
            errors++;
            $display("FAIL overflow_hold: got v=%b y=%0d sat=%b, expected v=0 y=%0d sat=%b",
                     bus.out_valid, bus.y_out, bus.sat_flag, exp_y, exp_s);
        end
        repeat (4) step(1'b1, 16'd0);
        idle(3);
    endtask

    task automatic test_valid_gaps();
        logic signed [15:0] got;
        set_coefs(16'h4000);
        idle(3);
        clear_obs();
        step(1'b1, 16'sd32767);
        repeat (4) begin
            step(1'b0, 16'h1234);
            step(1'b0, 16'h5678);
            step(1'b1, 16'd0);
        end
        idle(3);
        checks++;
        if (obs_y.size() != 5) begin errors++; $display("FAIL gaps_count: got %0d outputs, expected 5", obs_y.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < obs_y.size()) ? obs_y[i] : 16'hxxxx;
            checks++;
            if (got !== ((i < 4) ? 16'sd16384 : 16'sd0)) begin
                errors++;
                $display("FAIL gaps_y[%0d]: got %0d, expected %0d", i, got, (i < 4) ? 16384 : 0);
            end
        end
        checks++;
        if (obs_t.size() < 2 || obs_t[1] - obs_t[0] != 3) begin
            errors++;
            $display("FAIL gaps_spacing: got %0d, expected 3", (obs_t.size() < 2) ? -1 : obs_t[1] - obs_t[0]);
        end
    endtask

    task automatic test_coef_write();
        clear_obs();
        step(1'b1, 16'sd32767, 1'b1, 2'd0, 16'h2000);
        repeat (4) step(1'b1, 16'd0);
        step(1'b1, 16'sd32767);
        repeat (4) step(1'b1, 16'd0);
        idle(3);
        checks++;
        if (obs_y.size() != 10 || obs_y[0] !== 16'sd16384) begin
            errors++;
            $display("FAIL coef_same_cycle: got n=%0d y=%0d, expected n=10 y=16384", obs_y.size(),
                     (obs_y.size() > 0) ? obs_y[0] : 16'sd0);
        end
        checks++;
        if (obs_y.size() != 10 || obs_y[5] !== 16'sd8192 || obs_y[6] !== 16'sd16384) begin
            errors++;
            $display("FAIL coef_next: got y5=%0d y6=%0d, expected 8192 16384",
                     (obs_y.size() > 6) ? obs_y[5] : 16'sd0, (obs_y.size() > 6) ? obs_y[6] : 16'sd0);
        end
    endtask

    task automatic test_reset_midstream();
        set_coefs(16'h4000);
        idle(3);
        clear_obs();
        step(1'b1, 16'sd32767);
        step(1'b1, 16'h7FFF, 1'b1, 2'd0, 16'h4000, 1'b1);
        idle(4);
        checks++;
        if (obs_y.size() != 0) begin errors++; $display("FAIL midreset_out: got %0d outputs, expected 0", obs_y.size()); end
        checks++;
        if (bus.y_out !== 16'sd0) begin errors++; $display("FAIL midreset_y: got %0d, expected 0", bus.y_out); end
        step(1'b1, 16'sd32767);
        repeat (4) step(1'b1, 16'd0);
        idle(3);
        checks++;
        if (obs_y.size() != 5) begin errors++; $display("FAIL midreset_count: got %0d outputs, expected 5", obs_y.size()); end
        for (int i = 0; i < obs_y.size(); i++) begin
            checks++;
            if (obs_y[i] !== 16'sd0) begin errors++; $display("FAIL midreset_zero[%0d]: got %0d, expected 0", i, obs_y[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int t_bad;
        clear_obs();
        for (int i = 0; i < 40; i++)
            step(1'b1, 16'($urandom), ($urandom_range(3) == 0), 2'($urandom), 16'($urandom));
        idle(3);
        t_bad = 0;
        for (int i = 1; i < obs_t.size(); i++) if (obs_t[i] - obs_t[i-1] != 1) t_bad++;
        checks++;
        if (obs_y.size() != 40 || t_bad != 0) begin
            errors++;
            $display("FAIL b2b_stream: got n=%0d gaps=%0d, expected n=40 gaps=0", obs_y.size(), t_bad);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_out_of_range();
        logic signed [15:0] got6 [$];
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (bus6.out_valid === 1'b1) got6.push_back(bus6.y_out);
            #1;
            bus6.in_valid = 1'b0;
            bus6.coef_we = 1'b0;
            bus6.x_in = '0;
            bus6.coef_addr = 3'(i);
            bus6.coef_data = (i < 6) ? 16'h4000 : 16'h1000;
            if (i < 8) bus6.coef_we = 1'b1;
            else if (i < 15) begin
                bus6.in_valid = 1'b1;
                bus6.x_in = (i == 8) ? 16'sd32767 : 16'sd0;
            end
        end
        checks++;
        if (got6.size() != 7) begin errors++; $display("FAIL oor_count: got %0d outputs, expected 7", got6.size()); end
        for (int i = 0; i < got6.size(); i++) begin
            checks++;
            if (got6[i] !== ((i < 6) ? 16'sd16384 : 16'sd0)) begin
                errors++;
                $display("FAIL oor_y[%0d]: got %0d, expected %0d", i, got6[i], (i < 6) ? 16384 : 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.x_in = '0;
        bus.coef_we = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus6.in_valid = 1'b0;
        bus6.x_in = '0;
        bus6.coef_we = 1'b0;
        bus6.coef_addr = '0;
        bus6.coef_data = '0;
        test_reset();
        test_impulse();
        test_overflow();
        test_valid_gaps();
        test_coef_write();
        test_reset_midstream();
        test_back_to_back();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
